// File: rtl/issue_unit.sv
// -----------------------------------------------------------------------------
// issue_unit
//
// Single-issue dispatch stage sitting between the decoder and the ROB/RS/RF
// back end. Accepts one instruction per cycle over a valid/ready handshake,
// resolves both source operands (RF value, ROB value, live CDB broadcast, or
// rename tag), allocates a ROB index and presents one registered issue bundle.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable)
//   in_valid/in_ready, in_instr, in_pc, in_jumped    fetch handshake
//   dec_instr -> decoder; opcode, rs1, rs2, rd, imm <- decoder
//   rf_check1/2 -> RF; rf_val1/2, rf_dep1/2, rf_has_dep1/2 <- RF
//   rob_check1/2 -> ROB; rob_value_valid1/2, rob_value1/2 <- ROB
//   cdb_valid, cdb_index, cdb_value                  current broadcast
//   rob_commit, rs_full, flush                       back-end status
//   issue_valid, iss_*                               registered issue bundle
//   rob_used                                         ROB occupancy
// -----------------------------------------------------------------------------
module issue_unit #(
    parameter  int XLEN      = 32,
    parameter  int ROB_DEPTH = 64,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_jumped,
    output logic [31:0]      dec_instr,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [XLEN-1:0]  imm,
    output logic [4:0]       rf_check1,
    output logic [4:0]       rf_check2,
    input  logic [XLEN-1:0]  rf_val1,
    input  logic [XLEN-1:0]  rf_val2,
    input  logic [IDX_W-1:0] rf_dep1,
    input  logic [IDX_W-1:0] rf_dep2,
    input  logic             rf_has_dep1,
    input  logic             rf_has_dep2,
    output logic [IDX_W-1:0] rob_check1,
    output logic [IDX_W-1:0] rob_check2,
    input  logic             rob_value_valid1,
    input  logic             rob_value_valid2,
    input  logic [XLEN-1:0]  rob_value1,
    input  logic [XLEN-1:0]  rob_value2,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_index,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             rob_commit,
    input  logic             rs_full,
    input  logic             flush,
    output logic             issue_valid,
    output logic [IDX_W-1:0] iss_rob_index,
    output logic [4:0]       iss_rd,
    output logic [5:0]       iss_opcode,
    output logic [XLEN-1:0]  iss_pc,
    output logic [XLEN-1:0]  iss_imm,
    output logic             iss_jumped,
    output logic [XLEN-1:0]  iss_val1,
    output logic [XLEN-1:0]  iss_val2,
    output logic [IDX_W-1:0] iss_dep1,
    output logic [IDX_W-1:0] iss_dep2,
    output logic             iss_has_dep1,
    output logic             iss_has_dep2,
    output logic [IDX_W:0]   rob_used
);

    typedef struct packed {
        logic [XLEN-1:0]  val;
        logic [IDX_W-1:0] dep;
        logic             has_dep;
    } operand_t;

    logic [IDX_W-1:0] next_index;
    logic             byp_valid;
    logic [4:0]       last_rd;
    logic [IDX_W-1:0] last_index;

    logic             fire;
    logic             commit_eff;
    operand_t         op1;
    operand_t         op2;

    assign dec_instr  = in_instr;
    assign rf_check1  = rs1;
    assign rf_check2  = rs2;
    assign rob_check1 = rf_dep1;
    assign rob_check2 = rf_dep2;

    assign in_ready   = rdy & ~flush & ~rs_full & (rob_used < (IDX_W+1)'(ROB_DEPTH));
    assign fire       = in_valid & in_ready;
    // A commit against an empty ROB is ignored so occupancy cannot wrap.
    assign commit_eff = rob_commit & (rob_used != '0);

    // The RF only learns about the previous issue's rename one cycle late, so
    // the bypass register takes precedence over anything the RF reports.
    function automatic operand_t resolve(
        input logic [4:0]       rs,
        input logic [XLEN-1:0]  rf_val,
        input logic [IDX_W-1:0] rf_dep,
        input logic             rf_has_dep,
        input logic             rob_vv,
        input logic [XLEN-1:0]  rob_val,
        input logic             bv,
        input logic [4:0]       brd,
        input logic [IDX_W-1:0] bidx,
        input logic             cv,
        input logic [IDX_W-1:0] cidx,
        input logic [XLEN-1:0]  cval
    );
        operand_t r;
        r = '0;
        if (rs == 5'd0) begin
            r = '0;
        end else if (bv && brd != 5'd0 && rs == brd) begin
            r.has_dep = 1'b1;
            r.dep     = bidx;
        end else if (rf_has_dep && rob_vv) begin
            r.val = rob_val;
        end else if (rf_has_dep && cv && cidx == rf_dep) begin
            r.val = cval;
        end else if (rf_has_dep) begin
            r.has_dep = 1'b1;
            r.dep     = rf_dep;
        end else begin
            r.val = rf_val;
        end
        return r;
    endfunction

    // NOTE: every variable written in always_comb is given a value on every
    // path (here the function's default), otherwise a latch is inferred.
    always_comb begin
        op1 = resolve(rs1, rf_val1, rf_dep1, rf_has_dep1, rob_value_valid1, rob_value1,
                      byp_valid, last_rd, last_index, cdb_valid, cdb_index, cdb_value);
        op2 = resolve(rs2, rf_val2, rf_dep2, rf_has_dep2, rob_value_valid2, rob_value2,
                      byp_valid, last_rd, last_index, cdb_valid, cdb_index, cdb_value);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid   <= 1'b0;
            iss_rob_index <= '0;
            iss_rd        <= '0;
            iss_opcode    <= '0;
            iss_pc        <= '0;
            iss_imm       <= '0;
            iss_jumped    <= 1'b0;
            iss_val1      <= '0;
            iss_val2      <= '0;
            iss_dep1      <= '0;
            iss_dep2      <= '0;
            iss_has_dep1  <= 1'b0;
            iss_has_dep2  <= 1'b0;
            rob_used      <= '0;
            next_index    <= '0;
            byp_valid     <= 1'b0;
            last_rd       <= '0;
            last_index    <= '0;
        end else if (rdy) begin
            if (flush) begin
                issue_valid <= 1'b0;
                next_index  <= '0;
                rob_used    <= '0;
                byp_valid   <= 1'b0;
            end else begin
                if (fire) begin
                    issue_valid   <= 1'b1;
                    iss_rob_index <= next_index;
                    iss_rd        <= rd;
                    iss_opcode    <= opcode;
                    iss_pc        <= in_pc;
                    iss_imm       <= imm;
                    iss_jumped    <= in_jumped;
                    iss_val1      <= op1.val;
                    iss_val2      <= op2.val;
                    iss_dep1      <= op1.dep;
                    iss_dep2      <= op2.dep;
                    iss_has_dep1  <= op1.has_dep;
                    iss_has_dep2  <= op2.has_dep;
                    // Power-of-two depth: natural wrap gives the modulo.
                    next_index    <= next_index + 1'b1;
                    byp_valid     <= 1'b1;
                    last_rd       <= rd;
                    last_index    <= next_index;
                end else begin
                    issue_valid <= 1'b0;
                    byp_valid   <= 1'b0;
                end
                if (fire && !commit_eff) begin
                    rob_used <= rob_used + 1'b1;
                end else if (!fire && commit_eff) begin
                    rob_used <= rob_used - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_issue_unit
//
// Directed bench for issue_unit with ROB_DEPTH=4. Expected issue bundles are
// queued when an instruction is driven and compared when issue_valid appears.
// -----------------------------------------------------------------------------
module tb_issue_unit;

    localparam int XLEN      = 32;
    localparam int ROB_DEPTH = 4;
    localparam int IDX_W     = $clog2(ROB_DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             in_jumped;
    logic [31:0]      dec_instr;
    logic [5:0]       opcode;
    logic [4:0]       rs1, rs2, rd;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rf_check1, rf_check2;
    logic [XLEN-1:0]  rf_val1, rf_val2;
    logic [IDX_W-1:0] rf_dep1, rf_dep2;
    logic             rf_has_dep1, rf_has_dep2;
    logic [IDX_W-1:0] rob_check1, rob_check2;
    logic             rob_value_valid1, rob_value_valid2;
    logic [XLEN-1:0]  rob_value1, rob_value2;
    logic             cdb_valid;
    logic [IDX_W-1:0] cdb_index;
    logic [XLEN-1:0]  cdb_value;
    logic             rob_commit, rs_full, flush;
    logic             issue_valid;
    logic [IDX_W-1:0] iss_rob_index;
    logic [4:0]       iss_rd;
    logic [5:0]       iss_opcode;
    logic [XLEN-1:0]  iss_pc, iss_imm;
    logic             iss_jumped;
    logic [XLEN-1:0]  iss_val1, iss_val2;
    logic [IDX_W-1:0] iss_dep1, iss_dep2;
    logic             iss_has_dep1, iss_has_dep2;
    logic [IDX_W:0]   rob_used;

    issue_unit #(.XLEN(XLEN), .ROB_DEPTH(ROB_DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_jumped(in_jumped), .dec_instr(dec_instr),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .rf_check1(rf_check1), .rf_check2(rf_check2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rf_dep1(rf_dep1), .rf_dep2(rf_dep2),
        .rf_has_dep1(rf_has_dep1), .rf_has_dep2(rf_has_dep2),
        .rob_check1(rob_check1), .rob_check2(rob_check2),
        .rob_value_valid1(rob_value_valid1), .rob_value_valid2(rob_value_valid2),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_value(cdb_value),
        .rob_commit(rob_commit), .rs_full(rs_full), .flush(flush),
        .issue_valid(issue_valid), .iss_rob_index(iss_rob_index),
        .iss_rd(iss_rd), .iss_opcode(iss_opcode), .iss_pc(iss_pc),
        .iss_imm(iss_imm), .iss_jumped(iss_jumped),
        .iss_val1(iss_val1), .iss_val2(iss_val2),
        .iss_dep1(iss_dep1), .iss_dep2(iss_dep2),
        .iss_has_dep1(iss_has_dep1), .iss_has_dep2(iss_has_dep2),
        .rob_used(rob_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [4:0]       rd;
        logic [5:0]       op;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic             jumped;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [IDX_W-1:0] d1;
        logic [IDX_W-1:0] d2;
        logic             h1;
        logic             h2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        rf_val1 = '0; rf_val2 = '0; rf_dep1 = '0; rf_dep2 = '0;
        rf_has_dep1 = 1'b0; rf_has_dep2 = 1'b0;
        rob_value_valid1 = 1'b0; rob_value_valid2 = 1'b0;
        rob_value1 = '0; rob_value2 = '0;
        cdb_valid = 1'b0; cdb_index = '0; cdb_value = '0;
    endtask

    task automatic drive(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [5:0] op, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] im, input logic j);
        in_valid = 1'b1; rd = d; rs1 = s1; rs2 = s2; opcode = op;
        in_pc = pc; imm = im; in_jumped = j;
        in_instr = {op, s1, s2, d, 11'h2A5};
    endtask

    task automatic push(input logic [IDX_W-1:0] idx, input logic [4:0] d, input logic [5:0] op,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] im, input logic j,
                        input logic [XLEN-1:0] v1, input logic [IDX_W-1:0] d1, input logic h1,
                        input logic [XLEN-1:0] v2, input logic [IDX_W-1:0] d2, input logic h2);
        exp_t e;
        e.idx = idx; e.rd = d; e.op = op; e.pc = pc; e.imm = im; e.jumped = j;
        e.v1 = v1; e.d1 = d1; e.h1 = h1; e.v2 = v2; e.d2 = d2; e.h2 = h2;
        sb.push_back(e);
    endtask

    task automatic check_ready(input logic exp);
        #1;
        check("in_ready", 64'(in_ready), 64'(exp));
    endtask

    // Advance one edge, then compare against the scoreboard head when a new
    // issue is expected.
    task automatic tick(input logic exp_valid, input int exp_used, input logic new_issue);
        exp_t e;
        @(posedge clk);
        #1;
        check("issue_valid", 64'(issue_valid), 64'(exp_valid));
        check("rob_used", 64'(rob_used), 64'(exp_used));
        if (new_issue) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("iss_rob_index", 64'(iss_rob_index), 64'(e.idx));
                check("iss_rd",        64'(iss_rd),        64'(e.rd));
                check("iss_opcode",    64'(iss_opcode),    64'(e.op));
                check("iss_pc",        64'(iss_pc),        64'(e.pc));
                check("iss_imm",       64'(iss_imm),       64'(e.imm));
                check("iss_jumped",    64'(iss_jumped),    64'(e.jumped));
                check("iss_val1",      64'(iss_val1),      64'(e.v1));
                check("iss_dep1",      64'(iss_dep1),      64'(e.d1));
                check("iss_has_dep1",  64'(iss_has_dep1),  64'(e.h1));
                check("iss_val2",      64'(iss_val2),      64'(e.v2));
                check("iss_dep2",      64'(iss_dep2),      64'(e.d2));
                check("iss_has_dep2",  64'(iss_has_dep2),  64'(e.h2));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        in_jumped = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
        rob_commit = 1'b0; rs_full = 1'b0; flush = 1'b0;
        clear_ops();
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", 64'(issue_valid), 64'(0));
        check("rst_rob_used",    64'(rob_used),    64'(0));
        check("rst_rob_index",   64'(iss_rob_index), 64'(0));
        check("rst_imm",         64'(iss_imm),     64'(0));
        rst = 1'b1;

        // addi x1,x0,5 at pc 0
        drive(5'd1, 5'd0, 5'd0, 6'h04, 32'h0, 32'd5, 1'b0);
        #1;
        check("dec_instr", 64'(dec_instr), 64'({6'h04, 5'd0, 5'd0, 5'd1, 11'h2A5}));
        check("rf_check1", 64'(rf_check1), 64'(0));
        check_ready(1'b1);
        push(2'd0, 5'd1, 6'h04, 32'h0, 32'd5, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick(1'b1, 1, 1'b1);

        // add x2,x1,x1: RF not yet renamed, bypass must supply tag 0
        drive(5'd2, 5'd1, 5'd1, 6'h0C, 32'h4, 32'd0, 1'b1);
        rf_val1 = 32'h77; rf_val2 = 32'h77;
        push(2'd1, 5'd2, 6'h0C, 32'h4, 32'd0, 1'b1, 32'h0, 2'd0, 1'b1, 32'h0, 2'd0, 1'b1);
        tick(1'b1, 2, 1'b1);

        // CDB forward of a pending RF dependence
        clear_ops();
        drive(5'd4, 5'd3, 5'd0, 6'h0C, 32'h8, 32'd0, 1'b0);
        rf_has_dep1 = 1'b1; rf_dep1 = 2'd1;
        cdb_valid = 1'b1; cdb_index = 2'd1; cdb_value = 32'hDEAD;
        #1;
        check("rob_check1", 64'(rob_check1), 64'(1));
        push(2'd2, 5'd4, 6'h0C, 32'h8, 32'd0, 1'b0, 32'hDEAD, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick(1'b1, 3, 1'b1);

        // CDB index mismatch: dependence stays
        drive(5'd5, 5'd3, 5'd0, 6'h0C, 32'hC, 32'd0, 1'b0);
        cdb_index = 2'd2;
        push(2'd3, 5'd5, 6'h0C, 32'hC, 32'd0, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0, 2'd0, 1'b0);
        tick(1'b1, 4, 1'b1);
        clear_ops();

        // ROB full: no issue while held valid
        drive(5'd6, 5'd5, 5'd0, 6'h04, 32'h10, 32'd9, 1'b0);
        rf_val1 = 32'h1234;
        check_ready(1'b0);
        tick(1'b0, 4, 1'b0);

        // Single commit frees a slot next cycle
        rob_commit = 1'b1;
        check_ready(1'b0);
        tick(1'b0, 3, 1'b0);

        // Fire and commit together at 3: occupancy holds, index wraps to 0
        check_ready(1'b1);
        push(2'd0, 5'd6, 6'h04, 32'h10, 32'd9, 1'b0, 32'h1234, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick(1'b1, 3, 1'b1);
        rob_commit = 1'b0;

        // rs_full stalls three cycles, then the same instruction issues
        clear_ops();
        drive(5'd7, 5'd6, 5'd6, 6'h10, 32'h14, 32'hFFFF_FFF0, 1'b1);
        rf_has_dep1 = 1'b1; rf_dep1 = 2'd3; rob_value_valid1 = 1'b1; rob_value1 = 32'hBEEF;
        rf_has_dep2 = 1'b1; rf_dep2 = 2'd3;
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ready(1'b0);
            tick(1'b0, 3, 1'b0);
        end
        rs_full = 1'b0;
        check_ready(1'b1);
        push(2'd1, 5'd7, 6'h10, 32'h14, 32'hFFFF_FFF0, 1'b1, 32'hBEEF, 2'd0, 1'b0, 32'h0, 2'd3, 1'b1);
        tick(1'b1, 4, 1'b1);

        // Flush beats fire and commit
        clear_ops();
        drive(5'd8, 5'd0, 5'd0, 6'h04, 32'h18, 32'd1, 1'b0);
        flush = 1'b1; rob_commit = 1'b1;
        check_ready(1'b0);
        tick(1'b0, 0, 1'b0);
        flush = 1'b0; rob_commit = 1'b0;

        // Post-flush: index 0, stale bypass (rd 7) must not match
        drive(5'd9, 5'd7, 5'd0, 6'h04, 32'h40, 32'd2, 1'b0);
        rf_val1 = 32'h55;
        push(2'd0, 5'd9, 6'h04, 32'h40, 32'd2, 1'b0, 32'h55, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick(1'b1, 1, 1'b1);

        // rdy low freezes everything, including issue_valid
        rdy = 1'b0;
        check_ready(1'b0);
        tick(1'b1, 1, 1'b0);
        check("frozen_index", 64'(iss_rob_index), 64'(0));
        rdy = 1'b1; in_valid = 1'b0;
        tick(1'b0, 1, 1'b0);

        // Commit down to empty, then a commit at zero must not underflow
        rob_commit = 1'b1;
        tick(1'b0, 0, 1'b0);
        tick(1'b0, 0, 1'b0);
        rob_commit = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
